// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV64 core front end.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int BUS_DW = 64;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_HOLD = 3'd3,
        IFU_DROP = 3'd4
    } ifu_state_e;

    // Pick the 32-bit half of a bus beat addressed by pc[2].
    function automatic logic [INST_W-1:0] sel_inst(input logic [BUS_DW-1:0] rdata,
                                                   input logic              hi);
        return hi ? rdata[BUS_DW-1:INST_W] : rdata[INST_W-1:0];
    endfunction

endpackage

// File: rtl/config.sv
// Core-wide configuration macros shared by every RTL file of the CPU.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

// File: rtl/stdreg.sv
// Generic enable register with asynchronous active-low reset to a fixed value.
module stdreg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= RST_VAL;
        end else if (i_wen) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC handshake in, one 64-bit bus read, one 32-bit
// instruction held for decode, with redirect flush of in-flight fetches.
`ifndef CPU_WIDTH
`include "config.sv"
`endif

module ifu
    import cpu_pkg::*;
#(
    parameter int ADDR_W = `CPU_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pc_vld,
    output logic              o_pc_rdy,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvld,
    input  logic [BUS_DW-1:0] i_mem_rdata,
    input  logic              i_mem_err,
    output logic              o_inst_vld,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_fault_acc,
    output logic              o_fault_mis,
    input  logic              i_inst_rdy
);

    ifu_state_e        state;
    logic              drop_q;
    logic [ADDR_W-1:0] pc_q;
    logic              accept;
    logic              pc_mis;

    assign o_pc_rdy  = !i_flush && ((state == IFU_IDLE) ||
                                    ((state == IFU_HOLD) && i_inst_rdy));
    assign accept    = i_pc_vld && o_pc_rdy;
    assign pc_mis    = (i_pc[1:0] != 2'b00);
    assign o_mem_req = (state == IFU_REQ);

    stdreg #(
        .WIDTH   (ADDR_W),
        .RST_VAL ('0)
    ) u_pc_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wen   (accept),
        .i_d     (i_pc),
        .o_q     (pc_q)
    );

    // NOTE: the async reset clears every flop here; reset is sampled in the
    // sensitivity list, not only at clock edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IFU_IDLE;
            drop_q      <= 1'b0;
            o_mem_addr  <= '0;
            o_inst_vld  <= 1'b0;
            o_inst      <= '0;
            o_inst_pc   <= '0;
            o_fault_acc <= 1'b0;
            o_fault_mis <= 1'b0;
        end else begin
            case (state)
                IFU_IDLE, IFU_HOLD: begin
                    if (state == IFU_HOLD && i_flush) begin
                        state       <= IFU_IDLE;
                        o_inst_vld  <= 1'b0;
                        o_fault_acc <= 1'b0;
                        o_fault_mis <= 1'b0;
                    end else if (accept) begin
                        // A misaligned PC never reaches the bus; it is reported directly.
                        if (pc_mis) begin
                            state       <= IFU_HOLD;
                            o_inst_vld  <= 1'b1;
                            o_inst      <= '0;
                            o_inst_pc   <= i_pc;
                            o_fault_acc <= 1'b0;
                            o_fault_mis <= 1'b1;
                        end else begin
                            state       <= IFU_REQ;
                            o_mem_addr  <= {i_pc[ADDR_W-1:3], 3'b000};
                            o_inst_vld  <= 1'b0;
                            o_fault_acc <= 1'b0;
                            o_fault_mis <= 1'b0;
                        end
                    end else if (state == IFU_HOLD && i_inst_rdy) begin
                        state       <= IFU_IDLE;
                        o_inst_vld  <= 1'b0;
                        o_fault_acc <= 1'b0;
                        o_fault_mis <= 1'b0;
                    end
                end

                IFU_REQ: begin
                    // The request stays up until granted; a flush only marks the reply for discard.
                    if (i_mem_gnt) begin
                        drop_q <= 1'b0;
                        state  <= (drop_q || i_flush) ? IFU_DROP : IFU_WAIT;
                    end else if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                end

                IFU_WAIT: begin
                    if (i_flush) begin
                        state <= i_mem_rvld ? IFU_IDLE : IFU_DROP;
                    end else if (i_mem_rvld) begin
                        state       <= IFU_HOLD;
                        o_inst_vld  <= 1'b1;
                        o_inst      <= i_mem_err ? '0 : sel_inst(i_mem_rdata, pc_q[2]);
                        o_inst_pc   <= pc_q;
                        o_fault_acc <= i_mem_err;
                        o_fault_mis <= 1'b0;
                    end
                end

                IFU_DROP: begin
                    if (i_mem_rvld) begin
                        state <= IFU_IDLE;
                    end
                end

                default: state <= IFU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: fetch paths, faults, flushes and async reset.
`timescale 1ns/1ps

module tb_ifu;
    import cpu_pkg::*;

    localparam int AW = 64;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic          pc_vld;
    logic          pc_rdy;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvld;
    logic [63:0]   mem_rdata;
    logic          mem_err;
    logic          inst_vld;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          fault_acc;
    logic          fault_mis;
    logic          inst_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    ifu #(.ADDR_W(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pc        (pc),
        .i_pc_vld    (pc_vld),
        .o_pc_rdy    (pc_rdy),
        .i_flush     (flush),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_gnt   (mem_gnt),
        .i_mem_rvld  (mem_rvld),
        .i_mem_rdata (mem_rdata),
        .i_mem_err   (mem_err),
        .o_inst_vld  (inst_vld),
        .o_inst      (inst),
        .o_inst_pc   (inst_pc),
        .o_fault_acc (fault_acc),
        .o_fault_mis (fault_mis),
        .i_inst_rdy  (inst_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    localparam logic [63:0] RDATA = 64'h00A0_0093_0050_0113;

    initial begin
        rst_n = 1'b0; pc = '0; pc_vld = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        inst_rdy = 1'b0;
        #12;
        check("rst_inst_vld", 64'(inst_vld), 64'd0);
        check("rst_mem_req",  64'(mem_req), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_inst",     64'(inst), 64'd0);
        check("rst_inst_pc",  inst_pc, 64'd0);
        check("rst_faults",   {62'd0, fault_acc, fault_mis}, 64'd0);
        rst_n = 1'b1;
        step();

        // Aligned fetch, zero-wait memory, high word.
        pc = 64'h8000_0004; pc_vld = 1'b1;
        settle();
        check("al_pc_rdy", 64'(pc_rdy), 64'd1);
        step();                                    // cycle 1: REQ
        pc_vld = 1'b0; mem_gnt = 1'b1;
        settle();
        check("al_mem_req",  64'(mem_req), 64'd1);
        check("al_mem_addr", mem_addr, 64'h8000_0000);
        step();                                    // cycle 2: WAIT
        mem_gnt = 1'b0; mem_rvld = 1'b1; mem_rdata = RDATA;
        settle();
        check("al_req_drop", 64'(mem_req), 64'd0);
        check("al_vld_c2",   64'(inst_vld), 64'd0);
        step();                                    // cycle 3: HOLD
        mem_rvld = 1'b0; mem_rdata = '0;
        settle();
        check("al_inst_vld", 64'(inst_vld), 64'd1);
        check("al_inst",     64'(inst), 64'h00A0_0093);
        check("al_inst_pc",  inst_pc, 64'h8000_0004);
        check("al_faults",   {62'd0, fault_acc, fault_mis}, 64'd0);
        check("al_rdy_hold", 64'(pc_rdy), 64'd0);

        // Back-to-back: ready plus new PC in HOLD, low word selected.
        inst_rdy = 1'b1; pc = 64'h8000_0000; pc_vld = 1'b1;
        settle();
        check("lw_pc_rdy", 64'(pc_rdy), 64'd1);
        step();
        inst_rdy = 1'b0; pc_vld = 1'b0; mem_gnt = 1'b1;
        settle();
        check("lw_mem_req", 64'(mem_req), 64'd1);
        check("lw_vld_off", 64'(inst_vld), 64'd0);
        step();
        mem_gnt = 1'b0; mem_rvld = 1'b1; mem_rdata = RDATA;
        step();
        mem_rvld = 1'b0; mem_rdata = '1;
        settle();
        check("lw_inst", 64'(inst), 64'h0050_0113);
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            check("lw_stable_vld",  64'(inst_vld), 64'd1);
            check("lw_stable_inst", 64'(inst), 64'h0050_0113);
            check("lw_stable_pc",   inst_pc, 64'h8000_0000);
        end
        inst_rdy = 1'b1; pc = 64'h8000_0008; pc_vld = 1'b1;
        step();
        inst_rdy = 1'b0; pc_vld = 1'b0; mem_gnt = 1'b1;
        settle();
        check("nx_mem_req",  64'(mem_req), 64'd1);
        check("nx_mem_addr", mem_addr, 64'h8000_0008);
        step();
        mem_gnt = 1'b0; mem_rvld = 1'b1; mem_rdata = RDATA;
        step();
        mem_rvld = 1'b0;
        settle();
        check("nx_inst", 64'(inst), 64'h0050_0113);
        inst_rdy = 1'b1;
        step();
        inst_rdy = 1'b0;
        settle();
        check("nx_idle_vld", 64'(inst_vld), 64'd0);
        check("nx_idle_rdy", 64'(pc_rdy), 64'd1);

        // Misaligned PC: fault reported the next cycle, no bus request.
        pc = 64'h8000_0002; pc_vld = 1'b1;
        step();
        pc_vld = 1'b0;
        settle();
        check("mis_mem_req", 64'(mem_req), 64'd0);
        check("mis_vld",     64'(inst_vld), 64'd1);
        check("mis_fault",   64'(fault_mis), 64'd1);
        check("mis_inst",    64'(inst), 64'd0);
        check("mis_pc",      inst_pc, 64'h8000_0002);
        inst_rdy = 1'b1;
        step();
        inst_rdy = 1'b0;

        // Access error on the read response.
        pc = 64'h8000_0010; pc_vld = 1'b1;
        step();
        pc_vld = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvld = 1'b1; mem_err = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_rvld = 1'b0; mem_err = 1'b0;
        settle();
        check("err_vld",   64'(inst_vld), 64'd1);
        check("err_acc",   64'(fault_acc), 64'd1);
        check("err_mis",   64'(fault_mis), 64'd0);
        check("err_inst",  64'(inst), 64'd0);
        inst_rdy = 1'b1;
        step();
        inst_rdy = 1'b0;

        // Flush in REQ, grant two cycles later, response discarded.
        pc = 64'h8000_0020; pc_vld = 1'b1;
        step();
        pc_vld = 1'b0; flush = 1'b1;
        settle();
        check("frq_rdy_flush", 64'(pc_rdy), 64'd0);
        step();
        flush = 1'b0;
        settle();
        check("frq_req_held", 64'(mem_req), 64'd1);
        step();
        mem_gnt = 1'b1;
        step();                                    // DROP
        mem_gnt = 1'b0;
        settle();
        check("frq_drop_req", 64'(mem_req), 64'd0);
        check("frq_drop_rdy", 64'(pc_rdy), 64'd0);
        step();
        mem_rvld = 1'b1; mem_rdata = RDATA;
        settle();
        check("frq_rvld_rdy", 64'(pc_rdy), 64'd0);
        step();
        mem_rvld = 1'b0;
        settle();
        check("frq_no_vld", 64'(inst_vld), 64'd0);
        check("frq_rdy_back", 64'(pc_rdy), 64'd1);

        // Flush in WAIT coincident with the response.
        pc = 64'h8000_0030; pc_vld = 1'b1;
        step();
        pc_vld = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvld = 1'b1; flush = 1'b1;
        step();
        mem_rvld = 1'b0; flush = 1'b0;
        settle();
        check("fwt_no_vld", 64'(inst_vld), 64'd0);
        check("fwt_idle",   64'(pc_rdy), 64'd1);
        step();
        settle();
        check("fwt_still_no_vld", 64'(inst_vld), 64'd0);

        // Flush in HOLD.
        pc = 64'h8000_0004; pc_vld = 1'b1;
        step();
        pc_vld = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvld = 1'b1; mem_rdata = RDATA;
        step();
        mem_rvld = 1'b0;
        settle();
        check("fhd_vld_before", 64'(inst_vld), 64'd1);
        flush = 1'b1; inst_rdy = 1'b1; pc = 64'h8000_0040; pc_vld = 1'b1;
        settle();
        check("fhd_rdy_flush", 64'(pc_rdy), 64'd0);
        step();
        flush = 1'b0; inst_rdy = 1'b0; pc_vld = 1'b0;
        settle();
        check("fhd_vld_after", 64'(inst_vld), 64'd0);
        check("fhd_mem_req",   64'(mem_req), 64'd0);
        check("fhd_idle",      64'(pc_rdy), 64'd1);

        // Async reset asserted in WAIT, late response after release ignored.
        pc = 64'h8000_0048; pc_vld = 1'b1;
        step();
        pc_vld = 1'b0; mem_gnt = 1'b1;
        step();                                    // WAIT
        mem_gnt = 1'b0;
        settle();
        check("ar_addr_pre", mem_addr, 64'h8000_0048);
        rst_n = 1'b0;
        #1;
        check("ar_mem_addr", mem_addr, 64'd0);
        check("ar_inst_pc",  inst_pc, 64'd0);
        check("ar_inst",     64'(inst), 64'd0);
        check("ar_mem_req",  64'(mem_req), 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        mem_rvld = 1'b1; mem_rdata = RDATA;
        settle();
        check("ar_rdy", 64'(pc_rdy), 64'd1);
        step();
        mem_rvld = 1'b0;
        settle();
        check("ar_no_vld", 64'(inst_vld), 64'd0);
        step();
        settle();
        check("ar_no_vld2", 64'(inst_vld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the RV64 core. Accepts the next PC from the PC unit over a valid/ready handshake and issues one 64-bit read on the instruction memory bus. It extracts the addressed 32-bit instruction and holds it, with its PC and fault flags, until decode accepts it. It sits between the PC unit and decode, and provides redirect flush for taken branches and jumps.

## Interface
- `ADDR_W`, default `` `CPU_WIDTH `` (64): PC and bus address width.
- `i_clk` in 1: core clock; all state on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_pc` in ADDR_W: PC offered by the PC unit.
- `i_pc_vld` in 1: `i_pc` is valid.
- `o_pc_rdy` out 1: IFU accepts `i_pc` this cycle.
- `i_flush` in 1: redirect; discard any in-flight or held fetch.
- `o_mem_req` out 1: bus read request.
- `o_mem_addr` out ADDR_W: `{pc[ADDR_W-1:3], 3'b000}`.
- `i_mem_gnt` in 1: request accepted.
- `i_mem_rvld` in 1: read data valid.
- `i_mem_rdata` in 64: read data.
- `i_mem_err` in 1: access error, qualified by `i_mem_rvld`.
- `o_inst_vld` out 1: instruction valid to decode.
- `o_inst` out 32: instruction word.
- `o_inst_pc` out ADDR_W: PC of `o_inst`.
- `o_fault_acc` out 1: instruction access fault.
- `o_fault_mis` out 1: instruction address misaligned.
- `i_inst_rdy` in 1: decode accepts the instruction.

## Operation
- **States:** IDLE, REQ, WAIT, HOLD, DROP.
- **Accept condition:** `o_pc_rdy = !i_flush && (IDLE || (HOLD && i_inst_rdy))`. A PC transfers on `i_pc_vld && o_pc_rdy` and is latched into `pc_q`.
- **On accept:**
  - If `i_pc[1:0] != 0`, go to HOLD with `o_fault_mis=1` and `o_inst=0`. No bus request is made.
  - Otherwise go to REQ.
- **REQ:**
  - `o_mem_req=1` and is held until `i_mem_gnt`. A request is never withdrawn.
  - On gnt go to WAIT, or to DROP if a flush is pending (see below).
- **WAIT:**
  - On `i_mem_rvld`, capture `o_inst = pc_q[2] ? rdata[63:32] : rdata[31:0]` and `o_fault_acc = i_mem_err`, then go to HOLD.
  - When `i_mem_err=1`, `o_inst=32'h0`.
- **HOLD:**
  - `o_inst_vld=1`. Outputs stay stable until `i_inst_rdy`.
  - On handshake, go to REQ/HOLD (new PC accepted the same cycle) or to IDLE.
- **DROP:** wait for `i_mem_rvld`, discard the data, go to IDLE. `o_inst_vld=0`.
- **Flush:**
  - IDLE: no effect.
  - REQ: set sticky `drop_q`; on gnt go to DROP, clear `drop_q`.
  - WAIT: go to DROP. If `i_mem_rvld` arrives the same cycle, discard it and go to IDLE.
  - HOLD: go to IDLE, `o_inst_vld` drops next cycle.
  - DROP: no effect.
  - Flush has priority over `i_inst_rdy` and `i_mem_rvld`.
- **Bus rules:** at most one outstanding read. `i_mem_rvld` is ignored in IDLE, REQ and HOLD.

## Timing
- **Reset values:** state=IDLE, `o_mem_req=0`, `o_mem_addr=0`, `o_inst_vld=0`, `o_inst=0`, `o_inst_pc=0`, both faults 0. `o_pc_rdy=1` immediately after reset release.
- **Reset mid-operation:** return to IDLE asynchronously. A pending bus response after reset is ignored.
- **Zero-wait memory** (gnt same cycle as req, rvld next cycle):
  - PC accepted at cycle 0.
  - req/gnt at cycle 1.
  - rvld at cycle 2.
  - `o_inst_vld` at cycle 3.
  - With decode always ready, throughput is one instruction every 3 cycles.
- **Misaligned PC:** `o_inst_vld` rises the cycle after accept.
- **Outputs:** all outputs are registered except `o_pc_rdy` and `o_mem_req`. `o_mem_req` is a decode of state.
- **Combinational paths:** no path from `i_mem_rdata` to any output.

## Structure
- **`cpu_pkg`:**
  - `ifu_state_e` enum.
  - `INST_W=32`.
  - `BUS_DW=64`.
- Width comes from `` `CPU_WIDTH `` in `config.sv`.
- **`pc_q` register:** an instance of the existing `stdreg`, with `i_wen` = accept and reset value 0.
- The output holding registers and FSM are written inline. No other sub-module.

## Test plan
- **Aligned fetch, zero-wait:** PC `0x80000004`, rdata `0x00A0009300500113` → `o_mem_addr=0x80000000`; `o_inst=0x00A00093`, `o_inst_pc=0x80000004` at cycle 3.
- **Low-word select:** PC `0x80000000`, same rdata → `o_inst=0x00500113`. Hold `i_inst_rdy=0` for 4 cycles → outputs stable. Then ready plus next PC `0x80000008` the same cycle → `o_mem_req` the next cycle.
- **Misaligned PC:** `0x80000002` → no `o_mem_req`; `o_fault_mis=1`, `o_inst=0` the next cycle.
- **Access error:** rvld with `i_mem_err=1` → `o_fault_acc=1`, `o_inst=0`, `o_inst_vld=1`.
- **Flush cases:**
  - Flush in REQ with gnt 2 cycles later → DROP. rvld is discarded, no `o_inst_vld`, `o_pc_rdy` returns after rvld.
  - Flush in WAIT coincident with rvld → discarded, back in IDLE the next cycle.
  - Flush in HOLD → `o_inst_vld=0` the next cycle.
- **Async reset asserted in WAIT:** outputs go to 0 immediately. A late rvld after release produces no `o_inst_vld`.
